rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Registered round-robin arbiter for N requesters (default 4).
- Each clock it picks at most one asserted request and drives a one-hot grant.
- Priority rotates so the most recently granted requester becomes lowest priority.
- Sits in front of any shared resource (bus, memory port) needing fair single-owner access.

Parameters:
- N, 4, number of requesters; legal range 2..16; sets the width of req and grant.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset; single clock domain.
- req  input  N  request vector; bit i high = requester i wants the resource.
- grant  output  N  registered grant vector, one-hot or all-zero.

Behaviour:
- State:
  - grant register, N bits.
  - Priority pointer ptr, ceil(log2 N) bits; holds the index of the highest-priority requester for the next arbitration.
- Reset (rst=1, asynchronous, takes effect immediately regardless of clk):
  - grant = 0.
  - ptr = 0, so requester 0 has highest priority.
  - Reset asserted mid-operation clears both within the same timestep.
  - Arbitration resumes at the first rising edge after rst deasserts.
- Every rising edge with rst=0:
  - Search req starting at index ptr, ascending modulo N (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
  - First asserted bit k: grant <= one-hot(k); ptr <= (k+1) mod N.
  - req == 0: grant <= 0; ptr unchanged.
- Latency: grant reflects req sampled at the previous rising edge; exactly one cycle.
- No combinational path from req to grant.
- No grant locking: arbitration repeats every cycle. A requester that keeps req high is re-granted only when its turn comes, or when it is the sole requester.
- Invariants, checked every cycle:
  - popcount(grant) <= 1.
  - grant[i]=1 implies req[i] was 1 at the edge that produced it.
  - A requester dropping req gets no grant from the next edge onward.
- Wrap-around: when k = N-1, ptr becomes 0.
- Simultaneous requests:
  - Resolved purely by ptr order.
  - With all N requesting continuously, grants cycle 0,1,...,N-1,0,... (after reset).
  - Each requester is granted exactly once per N cycles.
- Fairness bound: a continuously requesting input waits at most N-1 cycles between grants.
- Sole requester: granted every cycle. ptr then always points just past it, which is harmless.
- Unknown (X) req bits are not required to be handled; the bench drives only 0/1.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=4'hF -> grant=4'b0000 throughout; first edge after release grants 4'b0001.
- All requesting: req=4'b1111 for 8 cycles after reset -> grants 0001,0010,0100,1000,0001,0010,0100,1000.
- Sparse plus wrap:
  - Setup: after reset, req=4'b1010 -> 0010, then 1000, then 0010 (wrap from index 3 past 0).
  - Then req=4'b0001 -> 0001 every cycle.
- Idle hold: grant 0100 (ptr=3), then req=0 for 3 cycles -> grant=0000, ptr stays 3; then req=4'b1001 -> 1000, next cycle 0001.
- Asynchronous reset mid-stream: req=4'b1111 running, assert rst between edges -> grant drops to 0000 immediately; after release, first grant is 0001.
- Random: 200 cycles of random 4-bit req -> popcount(grant)<=1 every cycle; no grant to a requester whose req was low at the sampling edge.

Source files
------------

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Registered round-robin arbiter. On each rising clock edge it grants at
//   most one of the asserted requests. The search starts at a rotating
//   priority pointer, so the requester granted most recently becomes the
//   lowest priority for the next arbitration.
//
// Parameters
//   N      number of requesters (2..16); sets the width of req and grant
//
// Ports
//   clk    rising-edge clock for all state
//   rst    asynchronous, active-high reset; clears grant and the pointer
//   req    request vector, bit i high = requester i wants the resource
//   grant  registered grant vector, one-hot or all-zero, one cycle after req
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  grant_r;
    logic [PW-1:0] ptr_r;
    logic [PW:0]   pick_res_s;
    logic          hit_s;
    logic [PW-1:0] pick_idx_s;
    logic [PW-1:0] ptr_nxt_s;
    logic [N-1:0]  onehot_s;

    // Search r starting at index p, ascending modulo N. Returns
    // {found, index of first asserted bit}; index is zero when nothing found.
    function automatic logic [PW:0] rr_pick(input logic [N-1:0] r,
                                            input logic [PW-1:0] p);
        logic [PW:0]   res;
        logic [PW-1:0] cand_idx;
        int            cand;
        res = {(PW+1){1'b0}};
        for (int i = 0; i < N; i++) begin
            cand     = (int'(p) + i) % N;
            cand_idx = PW'(cand);
            if (!res[PW] && r[cand_idx]) begin
                res = {1'b1, cand_idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Arbitration decision and the pointer/grant values it implies.
    always_comb begin
        pick_res_s = rr_pick(req, ptr_r);
        hit_s      = pick_res_s[PW];
        pick_idx_s = pick_res_s[PW-1:0];
        onehot_s   = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
        // Wrap explicitly so non-power-of-two N still returns to index 0.
        if (pick_idx_s == PW'(N - 1)) begin
            ptr_nxt_s = {PW{1'b0}};
        end else begin
            ptr_nxt_s = pick_idx_s + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Grant and priority-pointer registers; idle cycles leave the pointer alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_r <= {N{1'b0}};
            ptr_r   <= {PW{1'b0}};
        end else if (hit_s) begin
            grant_r <= onehot_s;
            ptr_r   <= ptr_nxt_s;
        end else begin
            grant_r <= {N{1'b0}};
            ptr_r   <= ptr_r;
        end
    end

    assign grant = grant_r;

endmodule

// File: tb/tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter
//   Directed and random checks of rr_arbiter with N = 4. Inputs are driven
//   on the falling edge, outputs sampled on the falling edge after the
//   rising edge that registers them.
// ---------------------------------------------------------------------------
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;

    int err_cnt;
    int chk_cnt;

    rr_arbiter #(.N(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got,
                         input logic [3:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive req, let one rising edge register it, check grant afterwards.
    task automatic step(input string tag, input logic [3:0] r,
                        input logic [3:0] exp);
        req = r;
        @(posedge clk);
        @(negedge clk);
        check(tag, grant, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'h0;
        @(negedge clk);
        check("rst_clear", grant, 4'b0000);
        rst = 1'b0;
    endtask

    // Reference: first asserted bit at or after ptr, modulo 4.
    logic [1:0] m_ptr;
    logic [3:0] m_exp;
    logic [3:0] prev_req;

    task automatic model_step(input logic [3:0] r);
        logic [1:0] idx;
        logic       done;
        done  = 1'b0;
        m_exp = 4'b0000;
        idx   = m_ptr;
        repeat (4) begin
            if (!done && r[idx]) begin
                done  = 1'b1;
                m_exp = 4'b0001 << idx;
                m_ptr = idx + 2'd1;
            end
            idx = idx + 2'd1;
        end
    endtask

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        rst     = 1'b1;
        req     = 4'hF;

        // Reset held for two edges with all requesting.
        @(negedge clk);
        check("rst_hold0", grant, 4'b0000);
        @(negedge clk);
        check("rst_hold1", grant, 4'b0000);
        rst = 1'b0;

        // All requesting: grants rotate 0,1,2,3 twice.
        step("all0", 4'hF, 4'b0001);
        step("all1", 4'hF, 4'b0010);
        step("all2", 4'hF, 4'b0100);
        step("all3", 4'hF, 4'b1000);
        step("all4", 4'hF, 4'b0001);
        step("all5", 4'hF, 4'b0010);
        step("all6", 4'hF, 4'b0100);
        step("all7", 4'hF, 4'b1000);

        // Sparse with wrap past index 0, then sole requester.
        do_reset();
        step("sparse0", 4'b1010, 4'b0010);
        step("sparse1", 4'b1010, 4'b1000);
        step("sparse2", 4'b1010, 4'b0010);
        step("sole0",   4'b0001, 4'b0001);
        step("sole1",   4'b0001, 4'b0001);
        step("sole2",   4'b0001, 4'b0001);

        // Idle hold: pointer stays at 3 across idle cycles.
        do_reset();
        step("idle_set", 4'b0100, 4'b0100);
        step("idle0",    4'b0000, 4'b0000);
        step("idle1",    4'b0000, 4'b0000);
        step("idle2",    4'b0000, 4'b0000);
        step("idle_r0",  4'b1001, 4'b1000);
        step("idle_r1",  4'b1001, 4'b0001);

        // Asynchronous reset between edges.
        do_reset();
        step("async_pre0", 4'hF, 4'b0001);
        step("async_pre1", 4'hF, 4'b0010);
        #2;
        rst = 1'b1;
        #1;
        check("async_clear", grant, 4'b0000);
        @(negedge clk);
        check("async_held", grant, 4'b0000);
        rst = 1'b0;
        step("async_post", 4'hF, 4'b0001);

        // Random traffic against the reference and the invariants.
        do_reset();
        m_ptr    = 2'd0;
        prev_req = 4'h0;
        for (int i = 0; i < 200; i++) begin
            prev_req = 4'($urandom_range(0, 15));
            req      = prev_req;
            model_step(prev_req);
            @(posedge clk);
            @(negedge clk);
            check("rnd_model", grant, m_exp);
            check("rnd_onehot", {3'b000, ($countones(grant) <= 1)}, 4'b0001);
            check("rnd_noreq", grant & ~prev_req, 4'b0000);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
